// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan/decode path.
// Select encodings are common to the scan controller and the decode stage.
package seg_pkg;

  localparam logic [3:0] SEL_A    = 4'b1000;
  localparam logic [3:0] SEL_B    = 4'b0100;
  localparam logic [3:0] SEL_C    = 4'b0010;
  localparam logic [3:0] SEL_D    = 4'b0001;
  localparam logic [3:0] SEL_NONE = 4'b0000;

  // 100 MHz / 100000 = 1 kHz per digit slot
  localparam int DEFAULT_REFRESH_DIV = 100000;

  // Slots that are leading zeros; D is never suppressed.
  function automatic logic [3:0] lead_zero_mask(input logic [3:0] a,
                                                input logic [3:0] b,
                                                input logic [3:0] c);
    logic za, zab, zabc;
    za   = (a == 4'h0);
    zab  = za && (b == 4'h0);
    zabc = zab && (c == 4'h0);
    return {za, zab, zabc, 1'b0};
  endfunction

endpackage

// File: rtl/refresh_tick_gen.sv
// Free-running divider producing a one-cycle tick every REFRESH_DIV enabled cycles.
// Holding the count at 0 while disabled gives a full dwell after re-enable.
module refresh_tick_gen #(
  parameter int REFRESH_DIV = seg_pkg::DEFAULT_REFRESH_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  assign tick = enable && (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (!enable || (div_cnt_q == DIV_LAST)) div_cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_cnt_q <= '0;
    else       div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit scan controller: rotating one-hot select, frame-aligned value
// updates through a shadow register, and optional leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic        blank_en,
  output logic [3:0]  A,
  output logic [3:0]  B,
  output logic [3:0]  C,
  output logic [3:0]  D,
  output logic [3:0]  disp_sel,
  output logic        frame_done,
  output logic        pending
);

  logic        tick, fb;
  logic [3:0]  slot_q, slot_d;
  logic [15:0] disp_q, disp_d;
  logic [15:0] shadow_q, shadow_d;
  logic        pending_q, pending_d;
  logic        frame_done_q;

  refresh_tick_gen #(.REFRESH_DIV(REFRESH_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  assign fb = tick && (slot_q == SEL_D);

  always_comb begin
    slot_d    = tick ? {slot_q[0], slot_q[3:1]} : slot_q;
    disp_d    = disp_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    // A load landing on the boundary bypasses the shadow entirely.
    if (fb) begin
      if (load)           disp_d = value_in;
      else if (pending_q) disp_d = shadow_q;
      pending_d = 1'b0;
    end else if (load) begin
      shadow_d  = value_in;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q       <= SEL_A;
      disp_q       <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      disp_q       <= disp_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      frame_done_q <= fb;
    end
  end

  assign {A, B, C, D} = disp_q;
  assign frame_done   = frame_done_q;
  assign pending      = pending_q;

  always_comb begin
    disp_sel = slot_q;
    if (!enable)
      disp_sel = SEL_NONE;
    else if (blank_en && ((slot_q & lead_zero_mask(disp_q[15:12], disp_q[11:8], disp_q[7:4])) != 4'h0))
      disp_sel = SEL_NONE;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Upstream driver for the four-digit seven-segment decode stage on the Basys 3.
- Time-multiplexes the four digit slots by generating a rotating one-hot digit select at a programmable refresh rate.
- Presents a 16-bit value as four nibbles A (leftmost) to D (rightmost).
- Accepts new values through a load strobe and applies them only at frame boundaries, so a digit never shows a half-updated value.
- Optional leading-zero blanking is done by driving an all-zero select during blanked slots; the decode stage then turns all anodes off.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot. At 100 MHz this gives 1 kHz per digit and 250 Hz per frame. Must be >= 2.
- DIV_W, $clog2(REFRESH_DIV): width of the divider counter (derived; do not override).

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  1 = scanning runs; 0 = display blanked and scan frozen.
- value_in  input  16  value to display; [15:12] goes to A, [3:0] goes to D.
- load  input  1  single-cycle strobe; captures value_in.
- blank_en  input  1  1 = suppress leading zero digits.
- A, B, C, D  output  4 each  displayed nibbles (registered).
- disp_sel  output  4  one-hot select: 1000 = A, 0100 = B, 0010 = C, 0001 = D, 0000 = blank.
- frame_done  output  1  one-cycle pulse when the scan wraps from slot D to slot A.
- pending  output  1  a loaded value is waiting for the next frame boundary.

Behaviour:
Reset (asynchronous, active-high):
- div_cnt = 0, slot = 1000, A/B/C/D = 0, shadow = 0, pending = 0, frame_done = 0.

Divider and tick:
- div_cnt counts 0 .. REFRESH_DIV-1 while enable = 1, then wraps to 0.
- tick = (div_cnt == REFRESH_DIV-1) && enable.
- When enable = 0, div_cnt is held at 0 and no ticks occur.

Slot rotation:
- On tick, slot rotates 1000 -> 0100 -> 0010 -> 0001 -> 1000.
- The slot register is never 0000 and never has more than one bit set.

Frame boundary:
- fb = tick && (slot == 0001).
- frame_done is registered and equals 1 for exactly the one cycle after fb.

Load and update:
- load = 1 and fb = 0: shadow <= value_in, pending <= 1. A later load before fb overwrites shadow (last write wins).
- fb = 1, load = 0, pending = 1: {A,B,C,D} <= shadow, pending <= 0.
- fb = 1 and load = 1 in the same cycle: {A,B,C,D} <= value_in directly, pending <= 0. The stale shadow is discarded.
- fb = 1 with pending = 0: outputs are unchanged.
- Resulting latency from load to visible change: 1 to 4*REFRESH_DIV cycles.

disp_sel (combinational from registered state):
- enable = 0: 0000.
- Otherwise equals slot, except that when blank_en = 1 and the current slot is a leading zero, it is 0000.
- Leading-zero rule:
  - A is blanked if A == 0.
  - B is blanked if A == 0 and B == 0.
  - C is blanked if A, B and C are all 0.
  - D is never blanked, so the value 0 shows as a single "0".

Enable transitions:
- Deasserting enable mid-frame freezes the slot; when re-enabled, scanning resumes from the same slot with a full REFRESH_DIV dwell.
- Loads are still accepted while disabled, but they stay pending because fb cannot occur.

Reset mid-operation:
- Discards pending data and returns all state to the reset values above, regardless of counter phase.

Decomposition:
Shared package seg_pkg:
- Constants SEL_A = 4'b1000, SEL_B = 4'b0100, SEL_C = 4'b0010, SEL_D = 4'b0001, SEL_NONE = 4'b0000.
- Default REFRESH_DIV for 100 MHz.
- The decode stage uses the same select constants.

Sub-module refresh_tick_gen:
- Parameter: REFRESH_DIV.
- Ports: clk, reset, enable, tick.
- Holds the divider counter, so the block can be reused for other scanned peripherals.

Test Plan (sim with REFRESH_DIV = 4):
1. Reset, then enable = 1, no load: disp_sel sequence is 1000 for 4 cycles, then 0100, 0010, 0001 (4 cycles each). frame_done is high for 1 cycle right after the 0001 slot ends. A-D stay at 0.
2. load with value_in = 16'h1234 at cycle 2 of slot A: pending = 1 immediately. A-D stay 0 until the frame boundary, then A-D = 1, 2, 3, 4 and pending = 0.
3. load 16'hAAAA, then load 16'h5C0F before the boundary: after the boundary, A-D = 5, C, 0, F. The value AAAA is never displayed.
4. load 16'hBEEF asserted on exactly the fb cycle while 16'h1111 is pending: the next outputs are B, E, E, F and pending = 0.
5. blank_en = 1 with the value 16'h0070: disp_sel is 0000 during the A and B slots, 0010 during C, 0001 during D. With the value 16'h0000, only the D slot is active.
6. Deassert enable during slot C: disp_sel = 0000, no frame_done. Re-enable: slot C resumes for 4 cycles. Assert reset mid-slot: disp_sel = 1000 and A-D = 0 immediately, without waiting for a clock edge.
